// File: rtl/usb_tx_pkg.sv
// Shared types and widths for the USB transmit CRC sequencer.
package usb_tx_pkg;
  localparam int CRC_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, DATA, CRC_WAIT, CRC, DONE
  } state_t;
endpackage

// File: rtl/usb_tx_bit_shifter.sv
// Loadable shift register, zero fill; i_dir_left selects MSB-first (left) or LSB-first (right).
module usb_tx_bit_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic         i_dir_left,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_q <= '0;
    else if (i_load)
      r_q <= i_load_val;
    else if (i_shift)
      r_q <= i_dir_left ? {r_q[W-2:0], 1'b0} : {1'b0, r_q[W-1:1]};
  end

  assign o_q = r_q;
endmodule

// File: rtl/usb_tx_crc_seq.sv
// USB TX payload/CRC-16 bit sequencer: serialises bytes LSB first, then the CRC MSB first.
// Define USB_CRC_INVERT_EN to transmit the complemented CRC.
module usb_tx_crc_seq
  import usb_tx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clk12,
  input  logic              pkt_start,
  input  logic              zlp,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  input  logic              last_byte,
  output logic              byte_ready,
  output logic              crc_en,
  output logic              reset_crc,
  output logic              crc_bit,
  input  logic [CRC_W-1:0]  crc_value,
  output logic              tx_bit,
  output logic              tx_bit_valid,
  output logic              busy,
  output logic              pkt_done,
  output logic              underrun
);
  state_t            r_state;
  logic              r_zlp;
  logic              r_last;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_crc_cnt;

  logic [BYTE_W-1:0] w_data_q;
  logic [CRC_W-1:0]  w_crc_q;
  logic [CRC_W-1:0]  w_crc_load;
  logic              w_in_data, w_in_crc, w_data_strb, w_byte_end;
  logic              w_take, w_reload, w_underrun;

  assign w_in_data   = (r_state == DATA);
  assign w_in_crc    = (r_state == CRC);
  assign w_data_strb = w_in_data & clk12;
  assign w_byte_end  = w_data_strb & (r_bit_cnt == 3'd7);
  assign w_take      = (r_state == LOAD) & byte_valid;
  // Next byte is loaded on the last strobe of the current one so bits stay back to back.
  assign w_reload    = w_byte_end & ~r_last & byte_valid;
  assign w_underrun  = w_byte_end & ~r_last & ~byte_valid;

`ifdef USB_CRC_INVERT_EN
  assign w_crc_load = ~crc_value;
`else
  assign w_crc_load = crc_value;
`endif

  usb_tx_bit_shifter #(.W(BYTE_W)) u_data_sr (
    .clk(clk), .n_rst(n_rst),
    .i_load(w_take | w_reload), .i_load_val(byte_data),
    .i_shift(w_data_strb), .i_dir_left(1'b0), .o_q(w_data_q)
  );

  usb_tx_bit_shifter #(.W(CRC_W)) u_crc_sr (
    .clk(clk), .n_rst(n_rst),
    .i_load(r_state == CRC_WAIT), .i_load_val(w_crc_load),
    .i_shift(w_in_crc & clk12), .i_dir_left(1'b1), .o_q(w_crc_q)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_zlp     <= 1'b0;
      r_last    <= 1'b0;
      r_bit_cnt <= '0;
      r_crc_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (pkt_start) begin
          r_zlp   <= zlp;
          r_state <= CLEAR;
        end
        CLEAR: r_state <= r_zlp ? CRC_WAIT : LOAD;
        LOAD: if (byte_valid) begin
          r_last    <= last_byte;
          r_bit_cnt <= '0;
          r_state   <= DATA;
        end
        DATA: if (clk12) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_last)          r_state <= CRC_WAIT;
            else if (byte_valid) r_last  <= last_byte;
            else                 r_state <= IDLE;
          end
        end
        CRC_WAIT: begin
          r_crc_cnt <= '0;
          r_state   <= CRC;
        end
        CRC: if (clk12) begin
          r_crc_cnt <= r_crc_cnt + 4'd1;
          if (r_crc_cnt == 4'd15) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign byte_ready   = (r_state == LOAD) | w_reload;
  assign tx_bit_valid = (w_in_data | w_in_crc) & clk12;
  assign crc_en       = w_data_strb;
  assign tx_bit       = w_in_data ? w_data_q[0] : (w_in_crc ? w_crc_q[CRC_W-1] : 1'b0);
  assign crc_bit      = w_in_data & w_data_q[0];
  assign reset_crc    = (r_state == CLEAR) | w_underrun;
  assign pkt_done     = (r_state == DONE);
  assign underrun     = w_underrun;
endmodule

// File: tb/tb_usb_tx_crc_seq.sv
// Directed bench for usb_tx_crc_seq with an external CRC-16 (poly 0x8005, reset 0) generator.
module tb_usb_tx_crc_seq;
  logic        clk = 0, n_rst = 0, clk12 = 0, pkt_start = 0, zlp = 0;
  logic [7:0]  byte_data = 0;
  logic        byte_valid = 0, last_byte = 0;
  logic        byte_ready, crc_en, reset_crc, crc_bit, tx_bit, tx_bit_valid;
  logic        busy, pkt_done, underrun;
  logic [15:0] gen;
  int checks = 0, errors = 0;
  int n_done = 0, n_crc_en = 0, n_valid = 0;

  usb_tx_crc_seq dut (
    .clk(clk), .n_rst(n_rst), .clk12(clk12), .pkt_start(pkt_start), .zlp(zlp),
    .byte_data(byte_data), .byte_valid(byte_valid), .last_byte(last_byte),
    .byte_ready(byte_ready), .crc_en(crc_en), .reset_crc(reset_crc), .crc_bit(crc_bit),
    .crc_value(gen), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .busy(busy),
    .pkt_done(pkt_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h8005;
    return c;
  endfunction

  // Expected transmitted CRC for up to two payload bytes.
  function automatic logic [15:0] exp_crc(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [15:0] c;
    c = 16'h0000;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) c = crc_step(c, (k == 0) ? b0[i] : b1[i]);
`ifdef USB_CRC_INVERT_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)         gen <= 16'h0000;
    else if (reset_crc) gen <= 16'h0000;
    else if (crc_en)    gen <= crc_step(gen, crc_bit);
  end

  always @(posedge clk) begin
    if (pkt_done)     n_done++;
    if (crc_en)       n_crc_en++;
    if (tx_bit_valid) n_valid++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_pkt(input logic z, input string tag);
    @(negedge clk);
    pkt_start = 1; zlp = z;
    @(negedge clk);
    pkt_start = 0; zlp = 0;
    #1;
    check({tag, "_clear"}, {30'd0, reset_crc, busy}, 32'd3);
  endtask

  task automatic strobe(output logic b, output logic v);
    clk12 = 1;
    #1;
    b = tx_bit; v = tx_bit_valid;
    @(negedge clk); clk12 = 0;
    @(negedge clk);
  endtask

  task automatic run_crc(input string tag, input logic [15:0] expv, input bit poke);
    logic [15:0] c;
    logic b, v;
    int nv;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      strobe(b, v);
      c[15-i] = b;
      nv += v;
      if (poke && i == 5) begin
        pkt_start = 1;
        @(negedge clk);
        pkt_start = 0;
      end
    end
    check({tag, "_crc"}, {16'd0, c}, {16'd0, expv});
    check({tag, "_crc_valid"}, nv, 16);
  endtask

  task automatic run_a5(input string tag, input bit poke);
    logic [7:0] d;
    logic b, v;
    int nv, ce0, d0;
    nv = 0; ce0 = n_crc_en; d0 = n_done;
    byte_data = 8'hA5; last_byte = 1; byte_valid = 1;
    start_pkt(0, tag);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 0;
    for (int i = 0; i < 8; i++) begin
      strobe(b, v);
      d[i] = b;
      nv += v;
    end
    check({tag, "_data"}, {24'd0, d}, 32'h0000_00A5);
    check({tag, "_data_valid"}, nv, 8);
    run_crc(tag, exp_crc(8'hA5, 8'h00, 1), poke);
    repeat (4) @(negedge clk);
    check({tag, "_crc_en_cnt"}, n_crc_en - ce0, 8);
    check({tag, "_done_cnt"}, n_done - d0, 1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic b, v;
    int nv, nz, v0, d0;

    // Reset: every output low even with strobe and start held high
    clk12 = 1; pkt_start = 1;
    #23;
    check("reset_outs", {23'd0, byte_ready, crc_en, reset_crc, crc_bit, tx_bit,
                         tx_bit_valid, busy, pkt_done, underrun}, 32'd0);
    clk12 = 0; pkt_start = 0;
    @(negedge clk); n_rst = 1;

    // Zero-length packet: CLEAR -> CRC_WAIT -> CRC
    d0 = n_done;
    start_pkt(1, "zlp");
    @(negedge clk); @(negedge clk);
    run_crc("zlp", exp_crc(8'h00, 8'h00, 0), 0);
    repeat (3) @(negedge clk);
    check("zlp_done_cnt", n_done - d0, 1);

    // Single byte 0xA5
    run_a5("a5", 0);

    // Two zero bytes, back to back
    d0 = n_done; nv = 0; nz = 0;
    byte_data = 8'h00; last_byte = 0; byte_valid = 1;
    start_pkt(0, "zz");
    @(negedge clk); @(negedge clk);
    last_byte = 1;
    for (int i = 0; i < 16; i++) begin
      strobe(b, v);
      nv += v;
      nz += (b === 1'b0) ? 1 : 0;
      if (i == 7) byte_valid = 0;
    end
    check("zz_data_valid", nv, 16);
    check("zz_data_zero", nz, 16);
    run_crc("zz", exp_crc(8'h00, 8'h00, 2), 0);
    repeat (3) @(negedge clk);
    check("zz_done_cnt", n_done - d0, 1);

    // Underrun: 0xFF not last, nothing offered at byte end
    byte_data = 8'hFF; last_byte = 0; byte_valid = 1;
    start_pkt(0, "ur");
    @(negedge clk); @(negedge clk);
    byte_valid = 0;
    for (int i = 0; i < 7; i++) strobe(b, v);
    clk12 = 1;
    #1;
    check("ur_pulse", {29'd0, underrun, reset_crc, byte_ready}, 32'd6);
    @(negedge clk); clk12 = 0;
    check("ur_busy", {31'd0, busy}, 32'd0);
    v0 = n_valid;
    clk12 = 1; @(negedge clk); clk12 = 0; @(negedge clk);
    check("ur_no_crc", n_valid - v0, 0);

    // Reset in the middle of a data byte
    d0 = n_done;
    byte_data = 8'hA5; last_byte = 1; byte_valid = 1;
    start_pkt(0, "mr");
    @(negedge clk); @(negedge clk);
    byte_valid = 0;
    for (int i = 0; i < 4; i++) strobe(b, v);
    n_rst = 0; clk12 = 1;
    #1;
    check("mr_outs", {23'd0, byte_ready, crc_en, reset_crc, crc_bit, tx_bit,
                      tx_bit_valid, busy, pkt_done, underrun}, 32'd0);
    @(negedge clk); clk12 = 0;
    @(negedge clk); n_rst = 1;
    repeat (2) @(negedge clk);
    check("mr_no_done", n_done - d0, 0);
    run_a5("mr_a5", 0);

    // pkt_start during CRC transmission is ignored
    run_a5("poke", 1);
    repeat (6) @(negedge clk);
    check("poke_stay_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/usb_tx_crc_seq.md
USB_TX_CRC_SEQ -- requirements
Module: usb_tx_crc_seq

Interface
REQ-001 SHALL have port clk  in  1  system clock; all flops on rising edge.
REQ-002 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have port clk12  in  1  bit strobe; one-cycle pulse per USB bit, pulses at least 2 clk cycles apart.
REQ-004 SHALL have port pkt_start  in  1  start-of-payload request, sampled in IDLE only.
REQ-005 SHALL have port zlp  in  1  zero-length packet flag, sampled with pkt_start.
REQ-006 SHALL have ports byte_data  in  8, byte_valid  in  1, last_byte  in  1, and byte_ready  out  1, which form the payload byte handshake.
REQ-007 SHALL have ports crc_en  out  1, reset_crc  out  1, and crc_bit  out  1 to drive the CRC-16 generator.
REQ-008 SHALL have port crc_value  in  16  current CRC-16 generator register.
REQ-009 SHALL have ports tx_bit  out  1 and tx_bit_valid  out  1, carrying the serial bit and its strobe-qualified valid.
REQ-010 SHALL have ports busy  out  1, pkt_done  out  1 (one-cycle pulse) and underrun  out  1 (one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, CLEAR, LOAD, DATA, CRC_WAIT, CRC, DONE.
REQ-012 IDLE: on pkt_start=1, SHALL go to CLEAR; busy is 0 only in IDLE.
REQ-013 CLEAR: SHALL assert reset_crc for exactly one cycle, then go to CRC_WAIT if zlp was captured, else to LOAD.
REQ-014 LOAD: SHALL assert byte_ready; on byte_valid=1 SHALL capture byte_data into an 8-bit shift register, capture last_byte, clear the bit count and go to DATA.
REQ-015 DATA: tx_bit SHALL equal shift register bit 0, sending the payload LSB first; crc_bit SHALL equal tx_bit.
REQ-016 DATA on clk12=1: tx_bit_valid=1, crc_en=1 (same cycle), shift right, increment the 3-bit bit count.
REQ-017 On the 8th data strobe of a byte with captured last_byte=0 and byte_valid=1, the block SHALL assert byte_ready, reload the shift register with byte_data in the same cycle and remain in DATA, leaving no bubble.
REQ-018 On the 8th data strobe with captured last_byte=0 and byte_valid=0, the block SHALL pulse underrun, pulse reset_crc and go to IDLE without sending CRC.
REQ-019 On the 8th data strobe with captured last_byte=1, the block SHALL go to CRC_WAIT.
REQ-020 CRC_WAIT: SHALL last one cycle, SHALL latch crc_value (already updated by the final crc_en) into a 16-bit CRC shift register, then go to CRC.
REQ-021 CRC: tx_bit SHALL equal the latched CRC bit 15, sending it MSB first; crc_en SHALL be 0.
REQ-022 CRC on each clk12=1: tx_bit_valid=1, shift left; after the 16th strobe the block SHALL go to DONE.
REQ-023 DONE: SHALL pulse pkt_done for one cycle, then go to IDLE.
REQ-024 tx_bit_valid, crc_en and byte_ready SHALL be 0 in all states and cycles not listed above.
REQ-025 pkt_start asserted while busy=1 SHALL be ignored.

Reset
REQ-026 On n_rst=0 the block SHALL asynchronously enter IDLE and clear all shift registers, counters and flags.
REQ-027 All outputs SHALL read 0 during reset, and reset mid-packet SHALL abandon the packet with no pkt_done.

Configuration
REQ-028 With macro USB_CRC_INVERT_EN defined, REQ-020 SHALL latch ~crc_value (the USB-compliant complement); without it, SHALL latch crc_value unmodified.

Structure
REQ-029 A shared package usb_tx_pkg SHALL hold the state enum type, CRC width 16 and byte width 8.
REQ-030 The block SHALL contain one sub-module, usb_tx_bit_shifter, a parameterised-width loadable shift register with selectable direction used for both data and CRC.

Verification
REQ-031 ZLP: pkt_start=1, zlp=1, INVERT_EN defined -> reset_crc pulse, 16 tx_bit_valid strobes all with tx_bit=1, then pkt_done.
REQ-032 One byte 0xA5, last_byte=1 -> tx_bit sequence 1,0,1,0,0,1,0,1, exactly 8 crc_en pulses, then 16 CRC bits equal to the model's ~CRC MSB first, then pkt_done.
REQ-033 Two bytes 0x00,0x00 without INVERT_EN -> 32 tx_bit=0 strobes, no gap between bytes, pkt_done.
REQ-034 Byte 0xFF with last_byte=0 and byte_valid low at the 8th strobe -> underrun pulse, no CRC bits, busy=0 on the next cycle.
REQ-035 n_rst=0 at DATA bit 4 -> all outputs 0 immediately; a subsequent pkt_start produces a correct packet.
REQ-036 pkt_start pulsed during the CRC state -> ignored; exactly one pkt_done.
